// File: rtl/trig_seq_ctrl_pkg.sv
// Shared definitions for the SRU trigger sequencer: FSM state encoding,
// default latency/timeout settings and the strobe width used downstream.
package trig_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_L1WAIT  = 3'd1,
      ST_L2WAIT  = 3'd2,
      ST_READOUT = 3'd3,
      ST_HOLDOFF = 3'd4
   } trig_state_t;

   localparam int unsigned DEF_L1_LAT_MIN = 5;
   localparam int unsigned DEF_L1_LAT_MAX = 8;
   localparam int unsigned DEF_L2_TIMEOUT = 20;
   localparam int unsigned STROBE_W       = 12;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/trig_win_timer.sv
// Loadable up-counter with terminal-count compare; reused for the L1 delay,
// the L2 decision window and the post-event holdoff.
module trig_win_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic [W-1:0] i_term,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/trig_seq_ctrl.sv
// SRU trigger sequencer: checks L0/L1/L2 timing, issues single-cycle command
// strobes, owns the busy line, sticky protocol-error flags and reject counter.
module trig_seq_ctrl
   import trig_seq_ctrl_pkg::*;
#(
   parameter int unsigned LAT_W   = 8,
   parameter int unsigned TO_W    = 16,
   parameter int unsigned HOLDOFF = 16,
   parameter int unsigned REJ_W   = 16
) (
   input  logic             gclk_40m,
   input  logic             reset,
   input  logic             l0,
   input  logic             l1,
   input  logic             l2a,
   input  logic             l2r,
   input  logic             rdo_done,
   input  logic [LAT_W-1:0] l1_lat_min,
   input  logic [LAT_W-1:0] l1_lat_max,
   input  logic [TO_W-1:0]  l2_timeout,
   input  logic             trigcnt_clr,
   output logic             l1out_c,
   output logic             rdocmd_c,
   output logic             abortcmd_c,
   output logic             busy,
   output logic             err_l1_early,
   output logic             err_l1_orph,
   output logic             err_l2_to,
   output logic             err_l2_both,
   output logic [REJ_W-1:0] rej_cnt
);

   localparam int unsigned     HO_W    = cnt_w(HOLDOFF);
   localparam logic [HO_W-1:0] HO_TERM = HO_W'(HOLDOFF);

   trig_state_t r_state;

   logic w_idle, w_l1wait, w_l2wait, w_readout, w_holdoff;
   logic w_l0_acc, w_l1_ok, w_l1_early, w_l1_orph;
   logic w_l2_acc, w_l2_both, w_l2_rej, w_l2_to, w_abort, w_ho_enter;
   logic [LAT_W-1:0] w_dly;
   logic [TO_W-1:0]  w_t2;
   logic [HO_W-1:0]  w_ho;
   logic w_dly_tc, w_t2_tc, w_ho_tc;
   logic w_unused;

   always_comb begin
      w_idle     = (r_state == ST_IDLE);
      w_l1wait   = (r_state == ST_L1WAIT);
      w_l2wait   = (r_state == ST_L2WAIT);
      w_readout  = (r_state == ST_READOUT);
      w_holdoff  = (r_state == ST_HOLDOFF);
      w_l0_acc   = w_idle & l0;
      w_l1_ok    = w_l1wait & l1 & (w_dly >= l1_lat_min) & (w_dly <= l1_lat_max);
      w_l1_early = w_l1wait & l1 & (w_dly < l1_lat_min);
      w_l1_orph  = l1 & (w_idle | w_l2wait | w_readout | w_holdoff);
      w_l2_both  = w_l2wait & l2a & l2r;
      w_l2_acc   = w_l2wait & l2a & ~l2r;
      w_l2_rej   = w_l2wait & l2r & ~l2a;
      w_l2_to    = w_l2wait & ~l2a & ~l2r & w_t2_tc;
      w_abort    = w_l2_both | w_l2_rej | w_l2_to;
      w_ho_enter = w_abort | (w_readout & rdo_done);
   end

   // Timers load 1 on the qualifying edge so each count equals the number of
   // cycles elapsed since that edge; terminal compare then fires on cycle N.
   trig_win_timer #(.W(LAT_W)) u_dly (
      .clk        (gclk_40m),
      .rst_n      (reset),
      .i_load     (w_l0_acc),
      .i_load_val (LAT_W'(1)),
      .i_en       (w_l1wait),
      .i_term     (l1_lat_max),
      .o_cnt      (w_dly),
      .o_tc       (w_dly_tc)
   );

   trig_win_timer #(.W(TO_W)) u_t2 (
      .clk        (gclk_40m),
      .rst_n      (reset),
      .i_load     (w_l1_ok),
      .i_load_val (TO_W'(1)),
      .i_en       (w_l2wait),
      .i_term     (l2_timeout),
      .o_cnt      (w_t2),
      .o_tc       (w_t2_tc)
   );

   trig_win_timer #(.W(HO_W)) u_ho (
      .clk        (gclk_40m),
      .rst_n      (reset),
      .i_load     (w_ho_enter),
      .i_load_val (HO_W'(1)),
      .i_en       (w_holdoff),
      .i_term     (HO_TERM),
      .o_cnt      (w_ho),
      .o_tc       (w_ho_tc)
   );

   assign w_unused = ^{w_t2, w_ho};

   always_ff @(posedge gclk_40m or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         l1out_c      <= 1'b0;
         rdocmd_c     <= 1'b0;
         abortcmd_c   <= 1'b0;
         busy         <= 1'b0;
         err_l1_early <= 1'b0;
         err_l1_orph  <= 1'b0;
         err_l2_to    <= 1'b0;
         err_l2_both  <= 1'b0;
         rej_cnt      <= '0;
      end else begin
         l1out_c    <= w_l1_ok;
         rdocmd_c   <= w_l2_acc;
         abortcmd_c <= w_abort;

         unique case (r_state)
            ST_IDLE: begin
               if (l0) r_state <= ST_L1WAIT;
            end
            ST_L1WAIT: begin
               if (w_l1_ok) begin
                  r_state <= ST_L2WAIT;
                  busy    <= 1'b1;
               end else if (l1 || w_dly_tc) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_L2WAIT: begin
               if (w_l2_acc)     r_state <= ST_READOUT;
               else if (w_abort) r_state <= ST_HOLDOFF;
            end
            ST_READOUT: begin
               if (rdo_done) r_state <= ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
               if (w_ho_tc) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase

         if (trigcnt_clr) begin
            err_l1_early <= 1'b0;
            err_l1_orph  <= 1'b0;
            err_l2_to    <= 1'b0;
            err_l2_both  <= 1'b0;
            rej_cnt      <= '0;
         end else begin
            if (w_l1_early) err_l1_early <= 1'b1;
            if (w_l1_orph)  err_l1_orph  <= 1'b1;
            if (w_l2_to)    err_l2_to    <= 1'b1;
            if (w_l2_both)  err_l2_both  <= 1'b1;
            if (l0 && busy && (rej_cnt != '1)) rej_cnt <= rej_cnt + REJ_W'(1);
         end
      end
   end

endmodule
